// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Timing-step generator and instruction latch for the Mk1 ALU
//               datapath. Accepts a 12-bit instruction word through a
//               valid/ready handshake, holds its fields stable for the
//               function-register decoder, and walks a one-hot step vector
//               T[4:0] one step per cycle until the decoder reports done.
//               If done has not arrived by the end of T[4], a sticky fault
//               is raised and held until clear_fault.
// Optional    : SEQ_SINGLE_STEP_EN - adds the 'step' input; EXEC transitions
//               then occur only on cycles with step=1.
// Ports       : clock, reset        - rising-edge clock, async active-high reset
//               instr_valid/instr_in - instruction offer {opcode,p1,p2,p3}
//               instr_ready          - high only in IDLE (combinational)
//               done                 - decoder completion strobe
//               clear_fault          - leave FAULT
//               step                 - advance enable (single-step build only)
//               T                    - one-hot step vector, 0 when not executing
//               opcode, p1, p2, p3   - latched instruction fields
//               busy                 - high in EXEC (combinational)
//               fault                - sticky missing-done flag
//               instr_count          - instructions retired via done (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   instr_valid,
    input  logic [11:0]            instr_in,
    output logic                   instr_ready,
    input  logic                   done,
    input  logic                   clear_fault,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [4:0]             T,
    output logic [2:0]             opcode,
    output logic [2:0]             p1,
    output logic [2:0]             p2,
    output logic [2:0]             p3,
    output logic                   busy,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [4:0]             c_T_FIRST   = 5'b00001;
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [4:0]             r_t;
    logic [4:0]             w_t_next;
    logic                   r_fault;
    logic                   w_fault_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_next;
    logic [11:0]            r_fields;
    logic                   w_load;
    logic                   w_step;

    // Without the single-step option the sequencer behaves as if step were
    // permanently asserted.
`ifdef SEQ_SINGLE_STEP_EN
    assign w_step = step;
`else
    assign w_step = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        w_fault_next = r_fault;
        w_count_next = r_count;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_load       = 1'b1;
                    w_t_next     = c_T_FIRST;
                    w_state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                // done has priority over the T[4] timeout, so a completion in
                // the last step retires cleanly instead of faulting.
                if (w_step) begin
                    if (done) begin
                        w_t_next     = 5'b00000;
                        w_count_next = r_count + c_COUNT_ONE;
                        w_state_next = S_IDLE;
                    end else if (r_t[4]) begin
                        w_t_next     = 5'b00000;
                        w_fault_next = 1'b1;
                        w_state_next = S_FAULT;
                    end else begin
                        w_t_next = {r_t[3:0], 1'b0};
                    end
                end
            end

            S_FAULT: begin
                // A simultaneous instr_valid is deliberately not accepted
                // here; the instruction must be re-offered in IDLE.
                w_t_next = 5'b00000;
                if (clear_fault) begin
                    w_fault_next = 1'b0;
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_t_next     = 5'b00000;
                w_fault_next = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_t      <= 5'b00000;
            r_fault  <= 1'b0;
            r_count  <= '0;
            r_fields <= 12'h000;
        end else begin
            r_state <= w_state_next;
            r_t     <= w_t_next;
            r_fault <= w_fault_next;
            r_count <= w_count_next;
            // Fields are only rewritten on accept, so they stay visible to
            // the decoder after retirement or fault.
            if (w_load) begin
                r_fields <= instr_in;
            end
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state == S_EXEC);
    assign T           = r_t;
    assign fault       = r_fault;
    assign instr_count = r_count;
    assign opcode      = r_fields[11:9];
    assign p1          = r_fields[8:6];
    assign p2          = r_fields[5:3];
    assign p3          = r_fields[2:0];

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Scoreboard bench for instruction_sequencer. Each directed
//               vector pushes its hand-computed expected outputs, tagged with
//               the cycle in which they must appear; a monitor pops and
//               compares them on the falling edge.
//               Define SEQ_SINGLE_STEP_EN to include the single-step vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic [11:0]   instr_in = 12'h000;
    logic          instr_ready;
    logic          done = 1'b0;
    logic          clear_fault = 1'b0;
    logic          step = 1'b1;
    logic [4:0]    T;
    logic [2:0]    opcode, p1, p2, p3;
    logic          busy;
    logic          fault;
    logic [CW-1:0] instr_count;

    instruction_sequencer #(.COUNT_WIDTH(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .instr_ready (instr_ready),
        .done        (done),
        .clear_fault (clear_fault),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .T           (T),
        .opcode      (opcode),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .busy        (busy),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            tag;
        string         name;
        logic [4:0]    t;
        logic          rdy;
        logic          bsy;
        logic          flt;
        logic [CW-1:0] cnt;
        logic [11:0]   fld;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        n_vec++;
        if (T !== e.t || instr_ready !== e.rdy || busy !== e.bsy ||
            fault !== e.flt || instr_count !== e.cnt ||
            {opcode, p1, p2, p3} !== e.fld) begin
            n_miss++;
            $display("FAIL %s: got T=%b rdy=%b busy=%b fault=%b cnt=%0d fld=%h, want T=%b rdy=%b busy=%b fault=%b cnt=%0d fld=%h",
                     e.name, T, instr_ready, busy, fault, instr_count,
                     {opcode, p1, p2, p3}, e.t, e.rdy, e.bsy, e.flt, e.cnt, e.fld);
        end
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.tag < cyc) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s: expectation for cycle %0d not checked, now %0d", e.name, e.tag, cyc);
            end else begin
                check(e);
            end
        end
    end

    task automatic expect_at(input int tag, input string name, input logic [4:0] et,
                             input logic er, input logic eb, input logic ef,
                             input logic [CW-1:0] ec, input logic [11:0] efld);
        exp_t e;
        e.tag = tag; e.name = name; e.t = et; e.rdy = er; e.bsy = eb;
        e.flt = ef; e.cnt = ec; e.fld = efld;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic apply(input string name, input logic v, input logic [11:0] ins,
                         input logic d, input logic clr, input logic [4:0] et,
                         input logic er, input logic eb, input logic ef,
                         input logic [CW-1:0] ec, input logic [11:0] efld);
        instr_valid = v;
        instr_in    = ins;
        done        = d;
        clear_fault = clr;
        expect_at(cyc + 1, name, et, er, eb, ef, ec, efld);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        @(posedge clock); #1;
        expect_at(cyc, "reset_state", 5'b0, 1, 0, 0, 2'd0, 12'h000);
        @(posedge clock); #1;
        reset = 1'b0;

        //     name            v  instr   d  clr  T         rdy bsy flt cnt  fields
        // Load: done during T[1]
        apply("load_accept",   1, 12'h2C0, 0, 0, 5'b00001, 0, 1, 0, 2'd0, 12'h2C0);
        apply("load_t1",       0, 12'h000, 0, 0, 5'b00010, 0, 1, 0, 2'd0, 12'h2C0);
        apply("load_retire",   0, 12'h000, 1, 0, 5'b00000, 1, 0, 0, 2'd1, 12'h2C0);
        apply("load_hold",     0, 12'h000, 0, 0, 5'b00000, 1, 0, 0, 2'd1, 12'h2C0);

        // Add: done during T[3], four busy cycles
        apply("add_t0",        1, 12'h653, 0, 0, 5'b00001, 0, 1, 0, 2'd1, 12'h653);
        apply("add_t1",        0, 12'h000, 0, 0, 5'b00010, 0, 1, 0, 2'd1, 12'h653);
        apply("add_t2",        0, 12'h000, 0, 0, 5'b00100, 0, 1, 0, 2'd1, 12'h653);
        apply("add_t3",        0, 12'h000, 0, 0, 5'b01000, 0, 1, 0, 2'd1, 12'h653);
        apply("add_retire",    0, 12'h000, 1, 0, 5'b00000, 1, 0, 0, 2'd2, 12'h653);
        apply("idle_done_ign", 0, 12'h000, 1, 0, 5'b00000, 1, 0, 0, 2'd2, 12'h653);

        // Undefined opcode 110: no done -> fault
        apply("undef_t0",      1, 12'hC00, 0, 0, 5'b00001, 0, 1, 0, 2'd2, 12'hC00);
        apply("undef_t1",      0, 12'h000, 0, 0, 5'b00010, 0, 1, 0, 2'd2, 12'hC00);
        apply("undef_t2",      0, 12'h000, 0, 0, 5'b00100, 0, 1, 0, 2'd2, 12'hC00);
        apply("undef_t3",      0, 12'h000, 0, 0, 5'b01000, 0, 1, 0, 2'd2, 12'hC00);
        apply("undef_t4",      0, 12'h000, 0, 0, 5'b10000, 0, 1, 0, 2'd2, 12'hC00);
        apply("undef_fault",   0, 12'h000, 0, 0, 5'b00000, 0, 0, 1, 2'd2, 12'hC00);
        apply("fault_ignore",  1, 12'h2C0, 1, 0, 5'b00000, 0, 0, 1, 2'd2, 12'hC00);
        apply("fault_clear",   1, 12'h2C0, 0, 1, 5'b00000, 1, 0, 0, 2'd2, 12'hC00);
        apply("after_clear",   0, 12'h000, 0, 0, 5'b00000, 1, 0, 0, 2'd2, 12'hC00);

        // done together with T[4]: done wins
        apply("last_t0",       1, 12'h0A5, 0, 0, 5'b00001, 0, 1, 0, 2'd2, 12'h0A5);
        apply("last_t1",       0, 12'h000, 0, 0, 5'b00010, 0, 1, 0, 2'd2, 12'h0A5);
        apply("last_t2",       0, 12'h000, 0, 0, 5'b00100, 0, 1, 0, 2'd2, 12'h0A5);
        apply("last_t3",       0, 12'h000, 0, 0, 5'b01000, 0, 1, 0, 2'd2, 12'h0A5);
        apply("last_t4",       0, 12'h000, 0, 0, 5'b10000, 0, 1, 0, 2'd2, 12'h0A5);
        apply("last_retire",   0, 12'h000, 1, 0, 5'b00000, 1, 0, 0, 2'd3, 12'h0A5);

        // Counter wrap 3 -> 0 -> 1
        apply("wrap_a_acc",    1, 12'h111, 0, 0, 5'b00001, 0, 1, 0, 2'd3, 12'h111);
        apply("wrap_a_ret",    0, 12'h000, 1, 0, 5'b00000, 1, 0, 0, 2'd0, 12'h111);
        apply("wrap_b_acc",    1, 12'h222, 0, 0, 5'b00001, 0, 1, 0, 2'd0, 12'h222);
        apply("wrap_b_ret",    0, 12'h000, 1, 0, 5'b00000, 1, 0, 0, 2'd1, 12'h222);

        // Asynchronous reset while T=00100
        apply("rst_t0",        1, 12'h3D2, 0, 0, 5'b00001, 0, 1, 0, 2'd1, 12'h3D2);
        apply("rst_t1",        0, 12'h000, 0, 0, 5'b00010, 0, 1, 0, 2'd1, 12'h3D2);
        apply("rst_t2",        0, 12'h000, 0, 0, 5'b00100, 0, 1, 0, 2'd1, 12'h3D2);
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        e.tag = cyc; e.name = "async_reset"; e.t = 5'b0; e.rdy = 1'b1; e.bsy = 1'b0;
        e.flt = 1'b0; e.cnt = 2'd0; e.fld = 12'h000;
        check(e);
        @(posedge clock); #1;
        reset = 1'b0;
        apply("post_reset",    0, 12'h000, 1, 0, 5'b00000, 1, 0, 0, 2'd0, 12'h000);

`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b1;
        apply("ss_accept",     1, 12'h4C8, 0, 0, 5'b00001, 0, 1, 0, 2'd0, 12'h4C8);
        step = 1'b0;
        apply("ss_hold1",      0, 12'h000, 1, 0, 5'b00001, 0, 1, 0, 2'd0, 12'h4C8);
        apply("ss_hold2",      0, 12'h000, 0, 0, 5'b00001, 0, 1, 0, 2'd0, 12'h4C8);
        apply("ss_hold3",      0, 12'h000, 1, 0, 5'b00001, 0, 1, 0, 2'd0, 12'h4C8);
        step = 1'b1;
        apply("ss_step1",      0, 12'h000, 0, 0, 5'b00010, 0, 1, 0, 2'd0, 12'h4C8);
        apply("ss_step2",      0, 12'h000, 0, 0, 5'b00100, 0, 1, 0, 2'd0, 12'h4C8);
        apply("ss_retire",     0, 12'h000, 1, 0, 5'b00000, 1, 0, 0, 2'd1, 12'h4C8);
`endif

        done = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
        @(negedge clock); #1;
        if (q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_sequencer.md
# instruction_sequencer

Timing-step generator and instruction latch for the Mk1 ALU datapath. Accepts 12-bit instruction words ({opcode, p1, p2, p3}) through a valid/ready handshake and holds them stable for the function-register decoder. Drives a one-hot step vector T[4:0], one step per cycle, until the decoder reports done. Flags a sticky fault if done never arrives, for example on undefined opcodes 110/111.

## Interface
- COUNT_WIDTH, 8: width of retired-instruction counter.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction word present on instr_in.
- instr_in  in  12  {opcode[11:9], p1[8:6], p2[5:3], p3[2:0]}.
- instr_ready  out  1  sequencer can accept an instruction; high only in IDLE.
- done  in  1  decoder completion strobe for current instruction.
- clear_fault  in  1  leave FAULT state.
- T  out  5  one-hot step vector, 0 when not executing.
- opcode, p1, p2, p3  out  3 each  latched instruction fields.
- busy  out  1  high in EXEC.
- fault  out  1  sticky: done missing by the end of T[4].
- instr_count  out  COUNT_WIDTH  instructions retired via done.
- step  in  1  present only with SEQ_SINGLE_STEP_EN; advance enable.

## Operation
- States: IDLE, EXEC, FAULT. Reset enters IDLE.
- IDLE:
  - instr_ready=1, T=0.
  - On instr_valid: latch instr_in into the field registers, load T=00001, go to EXEC.
- EXEC, evaluated each cycle:
  - done=1: T<=0, instr_count++, go to IDLE.
  - else T[4]=1: T<=0, fault<=1, go to FAULT.
  - else T<=T<<1.
- FAULT:
  - instr_ready=0, T=0, fault=1.
  - clear_fault=1: fault<=0, go to IDLE.
  - instr_valid is ignored in FAULT.
- Field registers hold their value after retirement or fault until the next accept.
- done is ignored in IDLE and FAULT.
- instr_count wraps from 2^COUNT_WIDTH-1 to 0.
- instr_ready and busy are decoded combinationally from the state. All other outputs are registered.

## Timing
- Reset values:
  - T=0, opcode/p1/p2/p3=0, fault=0, busy=0, instr_count=0.
  - instr_ready=1.
- Reset mid-execution aborts immediately: all of the above values, no count increment.
- Accept latency: handshake at edge k; T=00001 and fields valid during cycle k+1.
- Retire: done sampled high in step Tn at edge j; T=0 and instr_ready=1 during cycle j+1.
- Throughput: one mandatory IDLE cycle between instructions. An instruction retiring at T[1] costs 3 cycles including accept.
- done and T[4] in the same cycle: done wins, so no fault.
- clear_fault and instr_valid in the same cycle: clear only; the instruction is accepted on a later IDLE cycle.

## Configuration
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - The step port exists.
  - In EXEC, transitions (advance, retire, fault) occur only on cycles with step=1.
  - With step=0, T holds and done is ignored.
  - IDLE and FAULT are unaffected.
- Undefined:
  - No step port.
  - Behaves exactly as if step were tied to 1.

## Test plan
- Load: instr_in=001_011_000_000, valid for one cycle; done=1 while T=00010.
  - Expect T sequence 00001, 00010, then 0.
  - Expect p1=011 held, instr_count=1, instr_ready=1.
- Add: opcode 011, done asserted during T[3].
  - Expect 4 T steps.
  - Expect busy high for exactly 4 cycles, instr_count increments.
- Undefined opcode 110, done never asserted.
  - Expect T to reach 10000, then fault=1 and T=0 the next cycle, with instr_ready=0.
  - Assert clear_fault for 1 cycle: expect fault=0 and instr_ready=1.
- Reset asserted asynchronously while T=00100.
  - Expect T=0, fields=0, instr_count unchanged from reset value 0, state IDLE.
- Wrap: with COUNT_WIDTH=2, retire 5 instructions.
  - Expect instr_count 1, 2, 3, 0, 1.
- With SEQ_SINGLE_STEP_EN: accept an instruction, hold step=0 for 3 cycles.
  - Expect T to stay at 00001.
  - Then pulse step twice: expect T=00100.
